bist_engine: RTL

- Parametrised self-test engine: an LFSR pattern generator, a MISR response compactor and a run-control FSM in one block.
- Drives a fixed number of pseudo-random patterns into an external CUT, compacts the delayed CUT responses, then compares the signature against a golden value.
- Sits between the system test controller (start/done/pass handshake) and any CUT, combinational or pipelined.

---
 rtl/bist_pkg.sv | 16 +
 rtl/bist_misr.sv | 50 +++++
 rtl/bist_engine.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and default polynomials for the BIST engine.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_RUN,
      ST_FLUSH,
      ST_COMPARE,
      ST_DONE
   } state_t;

   localparam logic [7:0] DEF_LFSR_POLY = 8'hB8;
   localparam logic [3:0] DEF_MISR_POLY = 4'h9;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: folds a wide CUT response down to SIG_W bits
// and shifts it into a feedback register whenever capture is high.
module bist_misr
   import bist_pkg::*;
#(
   parameter int               SIG_W  = 4,
   parameter int               RESP_W = 8,
   parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_MISR_POLY)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              capture,
   input  logic [RESP_W-1:0] cut_resp,
   output logic [SIG_W-1:0]  misr
);

   localparam int N_SLICE = RESP_W / SIG_W;

   logic [SIG_W-1:0] misr_q;
   logic [SIG_W-1:0] misr_d;
   logic [SIG_W-1:0] fold;

   always_comb begin
      fold = '0;
      for (int i = 0; i < N_SLICE; i++) begin
         fold = fold ^ cut_resp[i*SIG_W +: SIG_W];
      end
   end

   always_comb begin
      misr_d = misr_q;
      if (clear) begin
         misr_d = '0;
      end else if (capture) begin
         misr_d = {misr_q[SIG_W-2:0], ^(misr_q & POLY)} ^ fold;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misr_q <= '0;
      end else begin
         misr_q <= misr_d;
      end
   end

   assign misr = misr_q;

endmodule

// File: rtl/bist_engine.sv
// Self-test engine: LFSR pattern source, MISR response compactor and run control.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for start, nothing valid
//   ST_SEED    | one cycle after launch, LFSR/MISR freshly loaded
//   ST_RUN     | NUM_PATTERNS cycles of valid pattern, LFSR advances
//   ST_FLUSH   | CUT_LAT cycles draining in-flight responses, pattern held
//   ST_COMPARE | latch signature and pass against golden_sig
//   ST_DONE    | result held, start relaunches
module bist_engine
   import bist_pkg::*;
#(
   parameter int               TPG_W        = 8,
   parameter logic [TPG_W-1:0] LFSR_POLY    = TPG_W'(DEF_LFSR_POLY),
   parameter logic [TPG_W-1:0] SEED         = TPG_W'(1),
   parameter int               RESP_W       = 8,
   parameter int               SIG_W        = 4,
   parameter logic [SIG_W-1:0] MISR_POLY    = SIG_W'(DEF_MISR_POLY),
   parameter int               NUM_PATTERNS = 16,
   parameter int               CUT_LAT      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [SIG_W-1:0]  golden_sig,
   output logic [TPG_W-1:0]  pattern,
   input  logic [RESP_W-1:0] cut_resp,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature
);

   localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
   localparam int FL_W  = (CUT_LAT > 1) ? $clog2(CUT_LAT) : 1;
   localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(NUM_PATTERNS - 1);
   localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);

   state_t           state_q, state_d;
   logic [TPG_W-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
   logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;
   logic             pass_q, pass_d;
   logic             done_q, done_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [SIG_W-1:0] misr;

   logic busy_c;
   logic issue;
   logic capture;
   logic launch;
   logic kill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_SEED;
            ST_SEED:          state_d = ST_RUN;
            ST_RUN: begin
               if (pat_cnt_q == LAST_PAT) begin
                  state_d = (CUT_LAT > 0) ? ST_FLUSH : ST_COMPARE;
               end
            end
            ST_FLUSH:         if (fl_cnt_q == '0) state_d = ST_COMPARE;
            ST_COMPARE:       state_d = ST_DONE;
            default:          state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_c = (state_q == ST_SEED) || (state_q == ST_RUN) ||
               (state_q == ST_FLUSH) || (state_q == ST_COMPARE);
      issue  = (state_q == ST_RUN);
      launch = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      kill   = abort && busy_c;
   end

   // Abort outranks everything; a launch reloads the generator and clears the old result.
   always_comb begin
      lfsr_d    = lfsr_q;
      pat_cnt_d = pat_cnt_q;
      fl_cnt_d  = fl_cnt_q;
      pass_d    = pass_q;
      sig_d     = sig_q;
      done_d    = 1'b0;
      if (kill) begin
         pass_d = 1'b0;
      end else if (launch) begin
         lfsr_d    = SEED;
         pat_cnt_d = '0;
         pass_d    = 1'b0;
         sig_d     = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               lfsr_d    = {lfsr_q[TPG_W-2:0], ^(lfsr_q & LFSR_POLY)};
               pat_cnt_d = pat_cnt_q + 1'b1;
               fl_cnt_d  = FL_LOAD;
            end
            ST_FLUSH: begin
               if (fl_cnt_q != '0) fl_cnt_d = fl_cnt_q - 1'b1;
            end
            ST_COMPARE: begin
               sig_d  = misr;
               pass_d = (misr == golden_sig);
               done_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q    <= SEED;
         pat_cnt_q <= '0;
         fl_cnt_q  <= '0;
         pass_q    <= 1'b0;
         done_q    <= 1'b0;
         sig_q     <= '0;
      end else begin
         lfsr_q    <= lfsr_d;
         pat_cnt_q <= pat_cnt_d;
         fl_cnt_q  <= fl_cnt_d;
         pass_q    <= pass_d;
         done_q    <= done_d;
         sig_q     <= sig_d;
      end
   end

   // Capture is the issue strobe delayed by the CUT pipeline depth.
   generate
      if (CUT_LAT == 0) begin : g_comb_cut
         assign capture = issue;
      end else begin : g_pipe_cut
         logic [CUT_LAT-1:0] pipe_q, pipe_d;

         always_comb begin
            pipe_d = kill ? '0 : ((pipe_q << 1) | CUT_LAT'(issue));
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pipe_q <= '0;
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign capture = pipe_q[CUT_LAT-1];
      end
   endgenerate

   bist_misr #(
      .SIG_W  (SIG_W),
      .RESP_W (RESP_W),
      .POLY   (MISR_POLY)
   ) u_misr (
      .clk      (clk),
      .rst      (rst),
      .clear    (launch && !kill),
      .capture  (capture),
      .cut_resp (cut_resp),
      .misr     (misr)
   );

   assign pattern   = lfsr_q;
   assign busy      = busy_c;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;

endmodule
